// File: rtl/snn_config_loader.sv
// snn_config_loader
//   Byte-serial configuration loader for the 3-layer SNN core. It assembles the
//   weight word and the neuron-parameter word in a shadow register from an 8-bit
//   stream. It then copies the shadow into the active registers in a single cycle,
//   so the core never sees a half-written configuration.
//
//   Optional feature macro: CFG_CHECKSUM_EN
//     When defined, a 40th byte carries the XOR of bytes 0..38. On a mismatch the
//     commit is skipped and cfg_err is raised.
//     When undefined, the load is 39 bytes with no check, and cfg_err is tied low.
//
//   Ports
//     clk, rst_n     clock, asynchronous active-low reset
//     load_start     pulse: begin or restart a load
//     data_in        configuration byte, qualified by data_valid
//     run_req        user run request
//     input_weights  active weights (byte 0 lands in the MSBs)
//     neuron_params  active neuron parameters (last data byte lands in the LSBs)
//     net_enable     registered run enable, forced low while loading/committing
//     load_busy      high in LOAD and COMMIT
//     cfg_valid      high after the first good commit
//     cfg_done       one-cycle pulse after a commit
//     cfg_err        sticky checksum error
//
//   state  | meaning
//   IDLE   | waiting for load_start, active config driving the core
//   LOAD   | accepting bytes into the shadow register
//   COMMIT | one cycle: shadow copied to active, cfg_done raised next cycle
module snn_config_loader #(
   parameter int WEIGHT_BITS = 216,
   parameter int PARAM_BITS  = 96
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load_start,
   input  logic [7:0]             data_in,
   input  logic                   data_valid,
   input  logic                   run_req,
   output logic [WEIGHT_BITS-1:0] input_weights,
   output logic [PARAM_BITS-1:0]  neuron_params,
   output logic                   net_enable,
   output logic                   load_busy,
   output logic                   cfg_valid,
   output logic                   cfg_done,
   output logic                   cfg_err
);

   localparam int CFG_BITS   = WEIGHT_BITS + PARAM_BITS;
   localparam int DATA_BYTES = CFG_BITS / 8;
`ifdef CFG_CHECKSUM_EN
   localparam int NUM_BYTES  = DATA_BYTES + 1;
`else
   localparam int NUM_BYTES  = DATA_BYTES;
`endif
   localparam logic [5:0] LAST_CNT = 6'(NUM_BYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [5:0]          byte_cnt_q, byte_cnt_d;
   logic [CFG_BITS-1:0] shadow_q, shadow_d;
   logic [CFG_BITS-1:0] active_q;
   logic                cfg_valid_q, cfg_done_q, net_en_q;
`ifdef CFG_CHECKSUM_EN
   logic [7:0]          xor_q, xor_d;
   logic                err_q, err_d;
`endif

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      shadow_d   = shadow_q;
`ifdef CFG_CHECKSUM_EN
      xor_d      = xor_q;
      err_d      = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (load_start) begin
               state_d    = ST_LOAD;
               byte_cnt_d = 6'd0;
`ifdef CFG_CHECKSUM_EN
               xor_d      = 8'd0;
               err_d      = 1'b0;
`endif
            end
         end
         ST_LOAD: begin
            // A restart takes priority over a byte arriving in the same cycle.
            if (load_start) begin
               byte_cnt_d = 6'd0;
`ifdef CFG_CHECKSUM_EN
               xor_d      = 8'd0;
`endif
            end else if (data_valid) begin
               if (byte_cnt_q == LAST_CNT) begin
                  byte_cnt_d = 6'd0;
`ifdef CFG_CHECKSUM_EN
                  // The final byte is the checksum. It is compared, not stored.
                  if (data_in == xor_q) begin
                     state_d = ST_COMMIT;
                  end else begin
                     state_d = ST_IDLE;
                     err_d   = 1'b1;
                  end
`else
                  shadow_d = {shadow_q[CFG_BITS-9:0], data_in};
                  state_d  = ST_COMMIT;
`endif
               end else begin
                  // The shift register puts byte 0 in the MSBs once all data bytes have
                  // arrived. A restarted load shifts the stale bytes out completely.
                  shadow_d   = {shadow_q[CFG_BITS-9:0], data_in};
                  byte_cnt_d = byte_cnt_q + 6'd1;
`ifdef CFG_CHECKSUM_EN
                  xor_d      = xor_q ^ data_in;
`endif
               end
            end
         end
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         byte_cnt_q  <= 6'd0;
         shadow_q    <= '0;
         active_q    <= '0;
         cfg_valid_q <= 1'b0;
         cfg_done_q  <= 1'b0;
         net_en_q    <= 1'b0;
`ifdef CFG_CHECKSUM_EN
         xor_q       <= 8'd0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         shadow_q   <= shadow_d;
         if (state_q == ST_COMMIT) begin
            active_q    <= shadow_q;
            cfg_valid_q <= 1'b1;
         end
         cfg_done_q <= (state_q == ST_COMMIT);
         net_en_q   <= run_req & cfg_valid_q & (state_q == ST_IDLE);
`ifdef CFG_CHECKSUM_EN
         xor_q      <= xor_d;
         err_q      <= err_d;
`endif
      end
   end

   assign input_weights = active_q[CFG_BITS-1:PARAM_BITS];
   assign neuron_params = active_q[PARAM_BITS-1:0];
   assign load_busy     = (state_q != ST_IDLE);
   // The registered enable lags one cycle. The gate keeps the core frozen from the
   // first LOAD cycle onward.
   assign net_enable    = net_en_q & ~load_busy;
   assign cfg_valid     = cfg_valid_q;
   assign cfg_done      = cfg_done_q;
`ifdef CFG_CHECKSUM_EN
   assign cfg_err       = err_q;
`else
   assign cfg_err       = 1'b0;
`endif

endmodule

// File: tb/tb_snn_config_loader.sv
// tb_snn_config_loader
//   Bench for snn_config_loader. Each load pushes its expected active word into a
//   queue. A negedge monitor pops from the queue and compares on every cfg_done
//   pulse. Checksum cases are built in when CFG_CHECKSUM_EN is defined.
module tb_snn_config_loader;

   localparam int NB = 39;

   logic         clk;
   logic         rst_n;
   logic         load_start;
   logic [7:0]   data_in;
   logic         data_valid;
   logic         run_req;
   logic [215:0] input_weights;
   logic [95:0]  neuron_params;
   logic         net_enable;
   logic         load_busy;
   logic         cfg_valid;
   logic         cfg_done;
   logic         cfg_err;

   int           n_checks;
   int           n_errors;
   int           done_cnt;
   logic [311:0] sb_q[$];
   logic [311:0] cur_cfg;
   logic [7:0]   pat [NB];

   snn_config_loader dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .load_start    (load_start),
      .data_in       (data_in),
      .data_valid    (data_valid),
      .run_req       (run_req),
      .input_weights (input_weights),
      .neuron_params (neuron_params),
      .net_enable    (net_enable),
      .load_busy     (load_busy),
      .cfg_valid     (cfg_valid),
      .cfg_done      (cfg_done),
      .cfg_err       (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [311:0] obs, input logic [311:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && cfg_done) begin
         done_cnt++;
         chk("sb_pending", 312'(sb_q.size()), 312'd1);
         if (sb_q.size() > 0) chk("sb_cfg", {input_weights, neuron_params}, sb_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) tick();
      data_in    = b;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
   endtask

   // Loads pat[] and checks commit latency, net_enable gating and output hold.
   task automatic full_load(input int gap, input bit collide, input bit bad_sum);
      logic [311:0] exp;
      logic [7:0]   x;
      int           d0;
      exp = '0;
      x   = 8'd0;
      d0  = done_cnt;
      load_start = 1'b1;
      if (collide) begin
         data_in    = 8'h55;
         data_valid = 1'b1;
      end
      tick();
      load_start = 1'b0;
      data_valid = 1'b0;
      chk("busy_after_start", 312'(load_busy), 312'd1);
      chk("ne_after_start", 312'(net_enable), 312'd0);
      for (int i = 0; i < NB; i++) begin
         send_byte(pat[i], gap);
         exp = {exp[303:0], pat[i]};
         x   = x ^ pat[i];
         chk("ne_during_load", 312'(net_enable), 312'd0);
      end
`ifdef CFG_CHECKSUM_EN
      send_byte(bad_sum ? (x ^ 8'h01) : x, gap);
`endif
      if (bad_sum) begin
         chk("err_set", 312'(cfg_err), 312'd1);
         chk("err_idle", 312'(load_busy), 312'd0);
         repeat (3) tick();
         chk("err_no_done", 312'(done_cnt), 312'(d0));
         chk("err_hold", {input_weights, neuron_params}, cur_cfg);
         return;
      end
      sb_q.push_back(exp);
      chk("commit_busy", 312'(load_busy), 312'd1);
      chk("commit_no_done", 312'(cfg_done), 312'd0);
      chk("pre_commit_hold", {input_weights, neuron_params}, cur_cfg);
      tick();
      chk("done_pulse", 312'(cfg_done), 312'd1);
      chk("post_commit_idle", 312'(load_busy), 312'd0);
      chk("ne_post_commit", 312'(net_enable), 312'd0);
      chk("cfg_valid", 312'(cfg_valid), 312'd1);
      chk("err_clear", 312'(cfg_err), 312'd0);
      tick();
      chk("done_end", 312'(cfg_done), 312'd0);
      chk("done_once", 312'(done_cnt), 312'(d0 + 1));
      chk("ne_resume", 312'(net_enable), 312'(run_req));
      cur_cfg = exp;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      done_cnt   = 0;
      cur_cfg    = '0;
      rst_n      = 1'b1;
      load_start = 1'b0;
      data_in    = 8'd0;
      data_valid = 1'b0;
      run_req    = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_active", {input_weights, neuron_params}, '0);
      chk("rst_flags", 312'({net_enable, load_busy, cfg_valid, cfg_done, cfg_err}), 312'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      run_req = 1'b1;
      tick();
      chk("ne_no_cfg", 312'(net_enable), 312'd0);

      // Full load of 0x01..0x27.
      for (int i = 0; i < NB; i++) pat[i] = 8'(i + 1);
      full_load(0, 1'b0, 1'b0);
      chk("w_top_byte", 312'(input_weights[215:208]), 312'h01);
      chk("p_low_byte", 312'(neuron_params[7:0]), 312'h27);

      // An aborted load leaves the outputs alone; the restart loads all zeros.
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 20; i++) send_byte(8'hFF, 0);
      chk("abort_hold", {input_weights, neuron_params}, cur_cfg);
      chk("abort_busy", 312'(load_busy), 312'd1);
      for (int i = 0; i < NB; i++) pat[i] = 8'h00;
      full_load(0, 1'b0, 1'b0);
      chk("abort_zero", {input_weights, neuron_params}, '0);

      // Bubbles between bytes give the same result as the gap-free load.
      for (int i = 0; i < NB; i++) pat[i] = 8'(i + 1);
      run_req = 1'b0;
      full_load(1, 1'b0, 1'b0);
      chk("gap_w_top", 312'(input_weights[215:208]), 312'h01);

      // A byte that arrives together with load_start is dropped.
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 5; i++) send_byte(8'hAA, 0);
      for (int i = 0; i < NB; i++) pat[i] = 8'(i * 3 + 7);
      full_load(0, 1'b1, 1'b0);

      // Enable gating follows run_req once a configuration is valid.
      tick();
      chk("ne_off", 312'(net_enable), 312'd0);
      run_req = 1'b1;
      tick();
      chk("ne_on", 312'(net_enable), 312'd1);
      for (int i = 0; i < NB; i++) pat[i] = 8'($urandom_range(0, 255));
      full_load(0, 1'b0, 1'b0);

`ifdef CFG_CHECKSUM_EN
      for (int i = 0; i < NB; i++) pat[i] = 8'($urandom_range(0, 255));
      full_load(0, 1'b0, 1'b1);
      full_load(0, 1'b0, 1'b0);
`endif

      // An asynchronous reset in the middle of a load clears everything at once.
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 10; i++) send_byte(8'h5A, 0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_mid_active", {input_weights, neuron_params}, '0);
      chk("rst_mid_flags", 312'({net_enable, load_busy, cfg_valid, cfg_done, cfg_err}), 312'd0);
      #8 rst_n = 1'b1;
      tick();
      for (int i = 0; i < NB; i++) send_byte(8'h33, 0);
      repeat (3) tick();
      chk("no_load_without_start", 312'({load_busy, cfg_valid}), 312'd0);
      chk("no_commit_without_start", {input_weights, neuron_params}, '0);
      chk("sb_drained", 312'(sb_q.size()), 312'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
